// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the MEM stage of the pipeline.
//   mem_state_t : memory-access FSM states (IDLE, WAIT)
//   DATA_W      : datapath width
//   REG_W       : register-index width
//   mem_wb_t    : MEM/WB pipeline register fields
//   BUBBLE      : MEM/WB contents for an inserted bubble (no writeback)
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              mem_to_reg;
        logic              reg_write;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_W-1:0]  reg_rd;
    } mem_wb_t;

    // A bubble must never write the register file, so every field is zero.
    localparam mem_wb_t BUBBLE = '0;

endpackage

// File: rtl/mem_wb_register.sv
// -----------------------------------------------------------------------------
// mem_wb_register
// MEM/WB pipeline register. Updates on the falling clock edge; loads either
// the presented fields or a bubble.
//   clk_i    : clock (falling-edge active)
//   rst_ni   : asynchronous active-low reset, clears to BUBBLE
//   bubble_i : 1 = load BUBBLE instead of d_i
//   d_i      : fields to load
//   q_o      : registered MEM/WB fields
// -----------------------------------------------------------------------------
module mem_wb_register
    import pipeline_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    bubble_i,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);

    mem_wb_t q_q;
    mem_wb_t q_d;

    always_comb begin
        q_d = bubble_i ? BUBBLE : d_i;
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage: performs the data-memory access over a req/ack
// handshake, resolves beq, and loads MEM/WB. Stalls upstream while an access
// waits; aborts an access after TIMEOUT wait edges and raises a sticky error.
//
// Handshake: dmem_req is held high (combinationally) for as long as an access
// is present; the access completes on the first falling edge at which
// dmem_ack is high, and dmem_rdata is sampled on that same edge. Address,
// write data and direction are held stable by the stall meanwhile.
//
// Ports
//   clock, reset               : falling-edge clock, async active-low reset
//   *_in (EX/MEM fields)       : control, branch flags, ALU result, store data,
//                                destination register
//   dmem_req/we/addr/wdata     : memory request
//   dmem_ack/rdata             : memory response
//   stall_out                  : freezes PC, IF/ID, ID/EX, EX/MEM
//   pc_src_out                 : branch taken
//   MEM/WB outputs             : mem_to_reg_out, reg_write_out, read_data_out,
//                                alu_result_out, reg_rd_out
//   mem_error_out              : sticky access-timeout flag
//   state_dbg_out              : current FSM state (observation only)
// -----------------------------------------------------------------------------
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              beq_instruction_in,
    input  logic              flag_beq_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mux2_result_in,
    input  logic [REG_W-1:0]  reg_rd_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_out,
    output logic              pc_src_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  reg_rd_out,
    output logic              mem_error_out,
    output mem_state_t        state_dbg_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    mem_state_t       state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             mem_error_q;

    logic    access;
    logic    abort;
    logic    bubble;
    mem_wb_t wb_d;
    mem_wb_t wb_q;

    assign access = mem_read_in | mem_write_in;

    // Abort only when the counter has reached TIMEOUT and no ack arrived;
    // an ack on that same cycle still completes the access.
    assign abort = (state_q == WAIT) && (wait_cnt_q == CNT_MAX) && !dmem_ack;

    assign dmem_req   = reset & access & ((state_q == IDLE) | (state_q == WAIT));
    // Read wins when both read and write are set.
    assign dmem_we    = mem_write_in & ~mem_read_in;
    assign dmem_addr  = alu_result_in;
    assign dmem_wdata = mux2_result_in;
    assign stall_out  = dmem_req & ~dmem_ack & ~abort;
    assign pc_src_out = reset & beq_instruction_in & flag_beq_in;

    // Any access edge without ack (waiting or aborting) writes a bubble.
    assign bubble = access & ~dmem_ack;

    always_comb begin
        wb_d            = BUBBLE;
        wb_d.mem_to_reg = mem_to_reg_in;
        wb_d.reg_write  = reg_write_in;
        wb_d.alu_result = alu_result_in;
        wb_d.reg_rd     = reg_rd_in;
        wb_d.read_data  = (mem_read_in && dmem_ack) ? dmem_rdata : '0;
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            if (!access || dmem_ack) begin
                state_q    <= IDLE;
                wait_cnt_q <= '0;
            end else if (abort) begin
                state_q     <= IDLE;
                wait_cnt_q  <= '0;
                mem_error_q <= 1'b1;
            end else if (state_q == IDLE) begin
                state_q    <= WAIT;
                wait_cnt_q <= CNT_W'(1);
            end else begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
        end
    end

    mem_wb_register u_mem_wb (
        .clk_i    (clock),
        .rst_ni   (reset),
        .bubble_i (bubble),
        .d_i      (wb_d),
        .q_o      (wb_q)
    );

    assign mem_to_reg_out = wb_q.mem_to_reg;
    assign reg_write_out  = wb_q.reg_write;
    assign read_data_out  = wb_q.read_data;
    assign alu_result_out = wb_q.alu_result;
    assign reg_rd_out     = wb_q.reg_rd;
    assign mem_error_out  = mem_error_q;
    assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Transaction-level reference: each access is described by its kind and the
// number of wait cycles before ack; the expected stall pattern, bubbles,
// final MEM/WB contents and error flag are derived from that description.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;
    import pipeline_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int WB_W = 2 + 2 * DATA_W + REG_W;

    // kinds
    localparam int K_NONE  = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;
    localparam int K_BOTH  = 3;

    logic              clock;
    logic              reset;
    logic              mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
    logic              beq_instruction_in, flag_beq_in;
    logic [DATA_W-1:0] alu_result_in, mux2_result_in;
    logic [REG_W-1:0]  reg_rd_in;
    logic              dmem_req, dmem_we, dmem_ack;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic              stall_out, pc_src_out, mem_to_reg_out, reg_write_out;
    logic [DATA_W-1:0] read_data_out, alu_result_out;
    logic [REG_W-1:0]  reg_rd_out;
    logic              mem_error_out;
    mem_state_t        state_dbg_out;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clock              (clock),
        .reset              (reset),
        .mem_to_reg_in      (mem_to_reg_in),
        .reg_write_in       (reg_write_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .beq_instruction_in (beq_instruction_in),
        .flag_beq_in        (flag_beq_in),
        .alu_result_in      (alu_result_in),
        .mux2_result_in     (mux2_result_in),
        .reg_rd_in          (reg_rd_in),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .stall_out          (stall_out),
        .pc_src_out         (pc_src_out),
        .mem_to_reg_out     (mem_to_reg_out),
        .reg_write_out      (reg_write_out),
        .read_data_out      (read_data_out),
        .alu_result_out     (alu_result_out),
        .reg_rd_out         (reg_rd_out),
        .mem_error_out      (mem_error_out),
        .state_dbg_out      (state_dbg_out)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [WB_W-1:0] exp_q[$];
    logic            exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [WB_W-1:0] got,
                            input logic [WB_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WB_W-1:0] wb_obs();
        return {mem_to_reg_out, reg_write_out, read_data_out, alu_result_out, reg_rd_out};
    endfunction

    // ---------------- driver ----------------
    // One transaction: kind, wait cycles before ack (> TIMEOUT means never).
    task automatic run_txn(input int kind, input int n_wait,
                           input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input logic [DATA_W-1:0] rdata, input logic [REG_W-1:0] rd,
                           input logic m2r, input logic rw, input logic beq, input logic flag);
        bit acc;
        bit rd_kind;
        bit timed_out;
        int last;
        logic [WB_W-1:0] exp_wb;
        acc       = (kind != K_NONE);
        rd_kind   = (kind == K_READ) || (kind == K_BOTH);
        timed_out = acc && (n_wait > TIMEOUT);
        last      = !acc ? 0 : ((n_wait < TIMEOUT) ? n_wait : TIMEOUT);
        for (int c = 0; c <= last; c++) begin
            if (c < last || timed_out) exp_q.push_back('0);
            else exp_q.push_back({m2r, rw, (rd_kind ? rdata : 32'h0), addr, rd});
        end
        for (int c = 0; c <= last; c++) begin
            @(posedge clock);
            #1;
            mem_read_in        = rd_kind;
            mem_write_in       = (kind == K_WRITE) || (kind == K_BOTH);
            mem_to_reg_in      = m2r;
            reg_write_in       = rw;
            beq_instruction_in = beq;
            flag_beq_in        = flag;
            alu_result_in      = addr;
            mux2_result_in     = wdata;
            reg_rd_in          = rd;
            dmem_ack           = acc ? (c == n_wait) : 1'($urandom_range(0, 1));
            dmem_rdata         = (acc && c == n_wait) ? rdata : $urandom;
            #1;
            check_eq("dmem_req", WB_W'(dmem_req), WB_W'(acc));
            check_eq("dmem_we", WB_W'(dmem_we), WB_W'(kind == K_WRITE));
            check_eq("dmem_addr", WB_W'(dmem_addr), WB_W'(addr));
            check_eq("dmem_wdata", WB_W'(dmem_wdata), WB_W'(wdata));
            check_eq("stall", WB_W'(stall_out), WB_W'(acc && c < n_wait && c < TIMEOUT));
            check_eq("pc_src", WB_W'(pc_src_out), WB_W'(beq & flag));
            @(negedge clock);
            #1;
            if (timed_out && c == last) exp_err = 1'b1;
            exp_wb = exp_q.pop_front();
            check_eq("mem_wb", wb_obs(), exp_wb);
            check_eq("mem_error", WB_W'(mem_error_out), WB_W'(exp_err));
        end
    endtask

    task automatic run_random(input int count);
        for (int i = 0; i < count; i++) begin
            run_txn($urandom_range(0, 3), $urandom_range(0, TIMEOUT + 2),
                    $urandom, $urandom, $urandom, 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        mem_to_reg_in = 0; reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
        beq_instruction_in = 1; flag_beq_in = 1;
        alu_result_in = '0; mux2_result_in = '0; reg_rd_in = '0;
        dmem_ack = 0; dmem_rdata = '0;
        #2;
        check_eq("rst_mem_wb", wb_obs(), '0);
        check_eq("rst_error", WB_W'(mem_error_out), '0);
        check_eq("rst_pc_src", WB_W'(pc_src_out), '0);
        check_eq("rst_state", WB_W'(state_dbg_out), WB_W'(IDLE));
        #10;
        reset = 1'b1;

        // no access, plain ALU result passes through
        run_txn(K_NONE, 0, 32'h1234, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        // read acked after 3 wait edges
        run_txn(K_READ, 3, 32'h40, 32'h0, 32'hDEADBEEF, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        // write with zero-wait ack
        run_txn(K_WRITE, 0, 32'h80, 32'hCAFE, 32'h5555_AAAA, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // branch taken / not taken
        run_txn(K_NONE, 0, 32'h10, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        run_txn(K_NONE, 0, 32'h10, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        // read and write both set behaves as read
        run_txn(K_BOTH, 1, 32'h44, 32'h9999, 32'h0BAD_F00D, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        // ack on the very cycle the counter hits TIMEOUT: no error
        run_txn(K_READ, TIMEOUT, 32'h48, 32'h0, 32'h1357_9BDF, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        // never acked: abort, sticky error
        run_txn(K_READ, 100, 32'h4C, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        run_txn(K_NONE, 0, 32'h77, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);

        run_random(40);

        // reset asserted in the middle of a wait
        @(posedge clock); #1;
        mem_read_in = 1; mem_write_in = 0; dmem_ack = 0;
        beq_instruction_in = 1; flag_beq_in = 1;
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        check_eq("mid_wait_stall", WB_W'(stall_out), WB_W'(1));
        reset = 1'b0;
        #1;
        exp_err = 1'b0;
        check_eq("rstw_req", WB_W'(dmem_req), '0);
        check_eq("rstw_stall", WB_W'(stall_out), '0);
        check_eq("rstw_pc_src", WB_W'(pc_src_out), '0);
        check_eq("rstw_mem_wb", wb_obs(), '0);
        check_eq("rstw_error", WB_W'(mem_error_out), '0);
        @(negedge clock); #2;
        reset = 1'b1;
        run_txn(K_READ, 2, 32'h100, 32'h0, 32'hFEED_BEEF, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);

        run_random(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
